// File: rtl/id_ex_if.sv
// id_ex_if: ID->EX stage bundle (decode fields in, registered EX fields and stall out)
interface id_ex_if #(parameter int DATA_W = 32, parameter int CNT_W = 16);
  logic              id_valid, id_MemtoReg, id_MemWrite, id_MemRead, id_Branch, id_ALUSrc, id_RegDst, id_RegWrite;
  logic [1:0]        id_ALUOp;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [5:0]        id_funct;
  logic              flush;
  logic              ex_valid, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_Branch, ex_ALUSrc, ex_RegDst, ex_RegWrite;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_funct;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_valid, id_MemtoReg, id_MemWrite, id_MemRead, id_Branch, id_ALUSrc, id_RegDst, id_RegWrite,
           id_ALUOp, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct, flush,
    input  ex_valid, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_Branch, ex_ALUSrc, ex_RegDst, ex_RegWrite,
           ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, stall, stall_cnt
  );
  modport slave (
    input  id_valid, id_MemtoReg, id_MemWrite, id_MemRead, id_Branch, id_ALUSrc, id_RegDst, id_RegWrite,
           id_ALUOp, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct, flush,
    output ex_valid, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_Branch, ex_ALUSrc, ex_RegDst, ex_RegWrite,
           ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, stall, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with flush/bubble insertion and load-use stall.
// Define ID_EX_HAZARD_DETECT_EN to enable load-use detection and the stall counter.
module id_ex_stage_reg #(parameter int DATA_W = 32, parameter int CNT_W = 16) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave p
);
  localparam int W = 4 * DATA_W + 31;
  logic [W-1:0]     d, q;
  logic [CNT_W-1:0] cnt;
  logic             hz, load;
`ifdef ID_EX_HAZARD_DETECT_EN
  logic uses_rt;
  assign uses_rt = !p.id_ALUSrc | p.id_MemWrite;
  assign hz = !p.flush & p.id_valid & p.ex_valid & p.ex_MemRead & (p.ex_rt != 5'd0) &
              ((p.ex_rt == p.id_rs) | (uses_rt & (p.ex_rt == p.id_rt)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (hz && cnt != '1) cnt <= cnt + 1'b1;
`else
  assign hz  = 1'b0;
  assign cnt = '0;
`endif
  assign p.stall     = hz;
  assign p.stall_cnt = cnt;
  assign load = !p.flush & !hz & p.id_valid;
  assign d = {p.id_valid, p.id_MemtoReg, p.id_MemWrite, p.id_MemRead, p.id_Branch, p.id_ALUSrc,
              p.id_RegDst, p.id_RegWrite, p.id_ALUOp, p.id_pc4, p.id_rd1, p.id_rd2, p.id_imm,
              p.id_rs, p.id_rt, p.id_rd, p.id_funct};
  // a bubble is an all-zero word, so X on unsupported-opcode controls never reaches EX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= load ? d : '0;
  assign {p.ex_valid, p.ex_MemtoReg, p.ex_MemWrite, p.ex_MemRead, p.ex_Branch, p.ex_ALUSrc,
          p.ex_RegDst, p.ex_RegWrite, p.ex_ALUOp, p.ex_pc4, p.ex_rd1, p.ex_rd2, p.ex_imm,
          p.ex_rs, p.ex_rt, p.ex_rd, p.ex_funct} = q;
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 5-stage MIPS pipeline. It captures the decode-stage control word (from the decode control unit) together with operands, immediate and register specifiers, and presents them to EX one cycle later. It also owns load-use hazard detection: it raises `stall` to hold PC and IF/ID, and inserts a bubble into EX. A branch-resolution flush squashes the entry.

## Interface
Parameters:
- `DATA_W`, 32: width of PC+4, register operands and immediate.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_MemtoReg`, `id_MemWrite`, `id_MemRead`, `id_Branch`, `id_ALUSrc`, `id_RegDst`, `id_RegWrite`  in  1 each  control bits from the decode control unit.
- `id_ALUOp`  in  2  ALU op class (00 add, 01 sub/beq, 10 funct).
- `id_pc4`, `id_rd1`, `id_rd2`, `id_imm`  in  DATA_W  PC+4, rs/rt read data, sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  5  register specifiers.
- `id_funct`  in  6  instruction [5:0].
- `flush`  in  1  taken branch resolved downstream; squash ID.
- `ex_*`  out  same widths as `id_*`  registered copies (`ex_valid`, control bits, `ex_ALUOp`, data, specifiers, `ex_funct`).
- `stall`  out  1  hold PC and IF/ID this cycle.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- Reset (`rst_n`=0, asynchronous): all `ex_*` outputs = 0, `stall_cnt` = 0. `stall` = 0 while in reset, because `ex_valid`=0.
- Each rising edge selects one load action. Priority is flush > stall > normal:
  - Flush (`flush`=1): load a bubble.
  - Stall (`stall`=1): load a bubble.
  - Normal: if `id_valid`=1, load all `id_*` fields and set `ex_valid`=1. If `id_valid`=0, load a bubble.
- Bubble definition:
  - `ex_valid`=0 and every control bit = 0, including `ex_ALUOp`=00.
  - Data and specifier fields = 0.
  - Bubble forcing overrides any X on the control inputs (the control unit drives X for unsupported opcodes).
- Load-use detection is combinational from EX state plus ID inputs:
  - `id_uses_rt` = `!id_ALUSrc | id_MemWrite` (R-type, beq, sw).
  - `stall` = `!flush & id_valid & ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`.
- A stall lasts exactly one cycle. The inserted bubble has `ex_MemRead`=0, so detection clears on the next cycle. ID contents are held upstream, so the instruction re-presents unchanged.
- `stall_cnt` increments on every edge where `stall`=1. It saturates at 2^CNT_W−1 and does not wrap.
- `$zero` never causes a stall (`ex_rt`=0 excluded).

## Timing
- Latency ID→EX: 1 cycle. Fields sampled on edge N appear on `ex_*` after edge N.
- `stall` is combinational in the same cycle. There is no register between `ex_*`/`id_*` and `stall`.
- Flush and stall in the same cycle: flush wins, `stall`=0, bubble loaded, `stall_cnt` unchanged.
- Reset asserted mid-stall: outputs clear immediately and `stall` drops in the same cycle. `stall_cnt` clears.
- Back-to-back lw→dependent→dependent: one stall only. The second dependent is ≥2 cycles behind the lw and is covered by forwarding.

## Configuration
- `ID_EX_HAZARD_DETECT_EN` defined:
  - Load-use detection as above.
  - `stall` and `stall_cnt` are live.
- Not defined:
  - `stall` is tied to 0 and `stall_cnt` is tied to 0.
  - Bubbles are inserted only by `flush`, `id_valid`=0 or reset.
  - For software-scheduled (nop-padded) programs.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `id_valid`=1 → all `ex_*` = 0, `stall`=0, `stall_cnt`=0 immediately without a clock edge.
- Pass-through: ID add $3,$1,$2 (RegWrite=1, RegDst=1, ALUOp=10, `id_rd1`=0x5, `id_rd2`=0x7) → next cycle `ex_valid`=1, `ex_ALUOp`=10, `ex_rd1`=5, `ex_rd2`=7, `ex_rd`=3, `stall`=0.
- Load-use: EX lw $2 (`ex_MemRead`=1, `ex_rt`=2), ID add $4,$2,$1 → `stall`=1 for exactly one cycle. EX then holds a bubble (`ex_valid`=0, all control 0), the add enters EX the following cycle, and `stall_cnt`=1.
- No false stall: EX lw $0 with ID using $0 → `stall`=0. EX lw $5 with ID addi $6,$5?: `id_rs`=5 gives `stall`=1, but `id_rt`=5 with ALUSrc=1 (addi dest) gives `stall`=0.
- Flush priority: load-use condition true and `flush`=1 in the same cycle → `stall`=0, bubble loaded, `stall_cnt` unchanged.
- Saturation (CNT_W=4): 20 consecutive forced load-use stalls → `stall_cnt` stops at 15.
